// File: rtl/stream_fifo.sv
// Order-preserving valid/ready FIFO between a stream source and sink.
// Occupancy is exported so stalls can be correlated with fill level.
module stream_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          up_ready,
  output logic          down_valid,
  output logic [DW-1:0] down_data,
  input  logic          down_ready,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          push_c;
  logic          pop_c;

  // Handshakes decode registered occupancy only; rst gating holds up_ready low in reset.
  assign up_ready   = rst & (count_q != FULL_CNT);
  assign down_valid = (count_q != '0);
  assign down_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign count      = count_q;

  assign push_c = up_valid & up_ready;
  assign pop_c  = down_valid & down_ready;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset; stale words are never exposed.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= up_data;
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed self-checking bench for stream_fifo (DW=32, DEPTH=4).
module tb_stream_fifo;

  logic        clk;
  logic        rst;
  logic        up_valid;
  logic [31:0] up_data;
  logic        up_ready;
  logic        down_valid;
  logic [31:0] down_data;
  logic        down_ready;
  logic [2:0]  count;

  int n_checks;
  int n_fail;

  stream_fifo #(.DW(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_ready (down_ready),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; up_valid = 1'b0; up_data = '0; down_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
      n_checks++;
      if (down_valid !== 1'b0) begin n_fail++; $display("FAIL reset_down_valid: got %b expected 0", down_valid); end
      n_checks++;
      if (up_ready !== 1'b0) begin n_fail++; $display("FAIL reset_up_ready: got %b expected 0", up_ready); end
      step();
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (up_ready !== 1'b1) begin n_fail++; $display("FAIL release_up_ready: got %b expected 1", up_ready); end
    n_checks++;
    if (down_valid !== 1'b0) begin n_fail++; $display("FAIL release_down_valid: got %b expected 0", down_valid); end
    step();
  endtask

  task automatic test_fill_drain();
    logic [31:0] vals [4];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
    down_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up_valid = 1'b1; up_data = vals[i];
      step();
      n_checks++;
      if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
    end
    up_valid = 1'b0;
    n_checks++;
    if (up_ready !== 1'b0) begin n_fail++; $display("FAIL fill_up_ready_full: got %b expected 0", up_ready); end
    down_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (down_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, down_valid); end
      n_checks++;
      if (down_data !== vals[i]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", i, down_data, vals[i]); end
      step();
    end
    down_ready = 1'b0;
    n_checks++;
    if (down_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_valid: got %b expected 0", down_valid); end
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", count); end
  endtask

  task automatic test_streaming();
    up_valid = 1'b1; down_ready = 1'b1; up_data = 32'd0;
    step();
    for (int k = 1; k <= 100; k++) begin
      n_checks++;
      if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d expected 1", k, count); end
      n_checks++;
      if (down_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, down_valid); end
      n_checks++;
      if (down_data !== 32'(k - 1)) begin n_fail++; $display("FAIL stream_data[%0d]: got %0d expected %0d", k, down_data, k - 1); end
      if (k < 100) up_data = 32'(k);
      else         up_valid = 1'b0;
      step();
    end
    down_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL stream_final_count: got %0d expected 0", count); end
    n_checks++;
    if (down_valid !== 1'b0) begin n_fail++; $display("FAIL stream_final_valid: got %b expected 0", down_valid); end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp [4];
    exp[0] = 32'h22; exp[1] = 32'h33; exp[2] = 32'h44; exp[3] = 32'h55;
    down_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up_valid = 1'b1; up_data = 32'(8'h11 * (i + 1));
      step();
    end
    n_checks++;
    if (count !== 3'd4) begin n_fail++; $display("FAIL fullpop_fill_count: got %0d expected 4", count); end
    up_data = 32'h55; down_ready = 1'b1;
    n_checks++;
    if (down_data !== 32'h11) begin n_fail++; $display("FAIL fullpop_head: got %h expected 11", down_data); end
    step();
    n_checks++;
    if (count !== 3'd3) begin n_fail++; $display("FAIL fullpop_count_after_pop: got %0d expected 3", count); end
    n_checks++;
    if (up_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_up_ready: got %b expected 1", up_ready); end
    down_ready = 1'b0;
    step();
    up_valid = 1'b0;
    n_checks++;
    if (count !== 3'd4) begin n_fail++; $display("FAIL fullpop_count_refill: got %0d expected 4", count); end
    down_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (down_data !== exp[i]) begin n_fail++; $display("FAIL fullpop_drain[%0d]: got %h expected %h", i, down_data, exp[i]); end
      step();
    end
    down_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL fullpop_final_count: got %0d expected 0", count); end
  endtask

  task automatic test_wrap();
    int seq_in;
    int seq_out;
    seq_in = 0; seq_out = 0;
    for (int r = 0; r < 10; r++) begin
      down_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        up_valid = 1'b1; up_data = 32'(seq_in + 1000);
        seq_in++;
        step();
      end
      up_valid = 1'b0;
      down_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (down_valid !== 1'b1 || down_data !== 32'(seq_out + 1000)) begin
          n_fail++;
          $display("FAIL wrap_data[%0d.%0d]: got valid=%b data=%0d expected valid=1 data=%0d", r, i, down_valid, down_data, seq_out + 1000);
        end
        seq_out++;
        step();
      end
      down_ready = 1'b0;
      n_checks++;
      if (count !== 3'd0) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected 0", r, count); end
    end
  endtask

  task automatic test_async_reset();
    down_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up_valid = 1'b1; up_data = 32'hA1 + 32'(i);
      step();
    end
    up_valid = 1'b0;
    n_checks++;
    if (count !== 3'd3) begin n_fail++; $display("FAIL areset_pre_count: got %0d expected 3", count); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (down_valid !== 1'b0) begin n_fail++; $display("FAIL areset_down_valid: got %b expected 0", down_valid); end
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL areset_count: got %0d expected 0", count); end
    step();
    rst = 1'b1;
    #1;
    n_checks++;
    if (down_valid !== 1'b0) begin n_fail++; $display("FAIL areset_release_valid: got %b expected 0", down_valid); end
    up_valid = 1'b1; up_data = 32'hAB;
    step();
    up_valid = 1'b0;
    n_checks++;
    if (down_valid !== 1'b1 || down_data !== 32'hAB) begin
      n_fail++;
      $display("FAIL areset_first_word: got valid=%b data=%h expected valid=1 data=ab", down_valid, down_data);
    end
    n_checks++;
    if (count !== 3'd1) begin n_fail++; $display("FAIL areset_new_count: got %0d expected 1", count); end
    down_ready = 1'b1;
    step();
    down_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0 || down_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_final: got count=%0d valid=%b expected count=0 valid=0", count, down_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill_drain();
    test_streaming();
    test_full_pop();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Synchronous valid/ready buffering stage between the stream generator's down port and the checker's up port.
- Absorbs back-pressure and bursty traffic.
- Order-preserving, lossless, no data modification.
- Exposes its occupancy so benches can correlate stalls with fill level.

Parameters:
- DW, 32: data width in bits.
- DEPTH, 4: number of entries. Power of two, minimum 2.
- AW, $clog2(DEPTH): pointer width. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low (0 = reset asserted).
- up_valid  input  1  upstream word available.
- up_data  input  DW  upstream word.
- up_ready  output  1  FIFO can accept a word this cycle.
- down_valid  output  1  FIFO holds a word for downstream.
- down_data  output  DW  head-of-FIFO word.
- down_ready  input  1  downstream accepts the word this cycle.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0): takes effect immediately, independent of clk.
  - Write and read pointers go to 0; count=0; down_valid=0; up_ready=0.
  - Storage array is not reset.
  - On release (rst=1), up_ready=1 from the first cycle; down_valid stays 0 until the first push.
- Push: when up_valid && up_ready at a rising edge, up_data is written at wr_ptr and wr_ptr increments.
- Pop: when down_valid && down_ready at a rising edge, rd_ptr increments.
- Pointers: AW+1 bits, wrapping modulo 2*DEPTH.
  - Storage is indexed by the low AW bits.
  - Full: MSBs differ and low bits are equal. Empty: pointers are equal.
- count: registered.
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Never exceeds DEPTH; never underflows.
- Handshake outputs: up_ready = (count != DEPTH); down_valid = (count != 0). Both are decoded from registered state only, with no combinational path from up_valid or down_ready.
- down_data: storage[rd_ptr]. Valid only when down_valid=1. Must hold stable while down_valid=1 and down_ready=0.
- Latency: a word pushed at edge N into an empty FIFO is presented with down_valid=1 after edge N. Minimum latency is 1 cycle; there is no combinational bypass.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Boundary conditions:
  - Full: up_ready=0, so no push. A pop in the same cycle frees an entry; up_ready=1 the next cycle.
  - Empty: down_valid=0, so no pop. A same-cycle push makes down_valid=1 the next cycle.
  - Simultaneous push and pop at 0 < count < DEPTH: count unchanged, both pointers advance.
  - up_valid while up_ready=0: ignored. The upstream must hold the word; the FIFO does not latch it.
  - Reset mid-burst: all contents are discarded immediately. down_valid drops asynchronously; no partial words appear after release.
- Ordering: strict FIFO. Every accepted word is delivered exactly once, in order.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release. Required: count=0, down_valid=0, up_ready=0 during reset; up_ready=1 on the first cycle after release.
- Fill then drain, DEPTH=4, down_ready=0: push 0x11, 0x22, 0x33, 0x44. Required: count steps 1→4 and up_ready=0 at count=4. Then set down_ready=1: outputs are 0x11, 0x22, 0x33, 0x44 in order, down_valid=0 after the 4th, count=0.
- Streaming: up_valid=1 and down_ready=1 continuously, incrementing data 0..99. Required: after the 1-cycle fill, one word per cycle with count=1 constant; all 100 words delivered in order.
- Full with simultaneous pop: fill to 4, then assert down_ready for one cycle while up_valid=1. Required: 0x11 pops, no push that cycle, count=3; the next cycle's push succeeds and count=4.
- Wrap-around: 10 rounds of push 3 / pop 3, sequential data. Required: no loss or duplication across pointer wrap; count returns to 0 after each round.
- Async reset mid-burst: with count=3, drive rst=0 between clock edges. Required: down_valid=0 and count=0 immediately. After release, a new push of 0xAB is the first word delivered.
